// File: rtl/level_sensor_pkg.sv
// level_sensor_pkg: FSM state type, legal thermometer codes and
// the legality helper shared by the level sensor conditioner.
package level_sensor_pkg;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        SUSPECT,
        FAULT
    } lsc_state_t;

    localparam logic [2:0] LEVEL_NONE = 3'b000;
    localparam logic [2:0] LEVEL_LOW  = 3'b001;
    localparam logic [2:0] LEVEL_MID  = 3'b011;
    localparam logic [2:0] LEVEL_FULL = 3'b111;

    function automatic logic is_legal_level(input logic [2:0] code);
        return (code == LEVEL_NONE) || (code == LEVEL_LOW) ||
               (code == LEVEL_MID)  || (code == LEVEL_FULL);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchroniser plus run-length debounce
// for one float-sensor line.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    // bring the asynchronous line into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // accept a new level only after an unbroken run of differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync != stable) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/level_sensor_conditioner.sv
// level_sensor_conditioner: debounced, legality-checked sensor bus
// with latched fault. Define LSC_FAILSAFE_EN to force s=000 in FAULT.
import level_sensor_pkg::*;

module level_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FAULT_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] s_raw,
    input  logic       fault_clr,
    output logic [2:0] s,
    output logic       s_valid,
    output logic       fault
);

    localparam int WW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam int FW = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;

    logic [2:0]    stable;
    logic          legal;
    lsc_state_t    state;
    logic [WW-1:0] wcnt;
    logic [FW-1:0] fcnt;

    for (genvar i = 0; i < 3; i++) begin : g_db
        sensor_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (s_raw[i]),
            .stable(stable[i])
        );
    end

    assign legal = is_legal_level(stable);

    // supervisor FSM: start-up wait, run, suspect window, latched fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            wcnt    <= '0;
            fcnt    <= '0;
            s       <= '0;
            s_valid <= 1'b0;
            fault   <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (wcnt == WW'(DEBOUNCE_CYCLES + 2)) begin
                        if (legal) begin
                            state   <= RUN;
                            s       <= stable;
                            s_valid <= 1'b1;
                        end else begin
                            state   <= SUSPECT;
                            s_valid <= 1'b0;
                            fcnt    <= '0;
                        end
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                RUN: begin
                    if (legal) begin
                        s <= stable;
                    end else begin
                        state <= SUSPECT;
                        fcnt  <= '0;
                    end
                end
                SUSPECT: begin
                    if (legal) begin
                        state   <= RUN;
                        s       <= stable;
                        s_valid <= 1'b1;
                        fcnt    <= '0;
                    end else if (fcnt == FW'(FAULT_CYCLES - 1)) begin
                        state   <= FAULT;
                        fault   <= 1'b1;
                        s_valid <= 1'b0;
`ifdef LSC_FAILSAFE_EN
                        s       <= '0;
`endif
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                FAULT: begin
`ifdef LSC_FAILSAFE_EN
                    s <= '0;
`endif
                    if (fault_clr && legal) begin
                        state   <= RUN;
                        fault   <= 1'b0;
                        s       <= stable;
                        s_valid <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// tb_level_sensor_conditioner: directed scenarios plus random
// stimulus checked against a cycle-level behavioural model.
module tb_level_sensor_conditioner;

    localparam int D = 4;
    localparam int F = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] s_raw = 3'b000;
    logic       fault_clr = 1'b0;
    logic [2:0] s;
    logic       s_valid;
    logic       fault;

    int total = 0;
    int bad = 0;

    level_sensor_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .FAULT_CYCLES   (F)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_raw    (s_raw),
        .fault_clr(fault_clr),
        .s        (s),
        .s_valid  (s_valid),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    typedef enum {M_INIT, M_RUN, M_SUS, M_FLT} mstate_t;

    logic [2:0] hist[$];
    logic [2:0] m_st;
    logic [2:0] m_s;
    logic       m_v;
    logic       m_f;
    mstate_t    mst;
    int         edges;
    int         sus_bad;

    function automatic bit legal(input logic [2:0] c);
        return c inside {3'b000, 3'b001, 3'b011, 3'b111};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < D + 2; j++) hist.push_back(3'b000);
        m_st = 3'b000;
        m_s = 3'b000;
        m_v = 1'b0;
        m_f = 1'b0;
        mst = M_INIT;
        edges = 0;
        sus_bad = 0;
    endtask

    task automatic model_step();
        logic [2:0] nst;
        bit all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        hist.push_front(s_raw);
        void'(hist.pop_back());
        nst = m_st;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1;
            for (int j = 2; j <= D + 1; j++)
                if (hist[j][b] == m_st[b]) all_diff = 0;
            if (all_diff) nst[b] = ~m_st[b];
        end
        edges++;
        case (mst)
            M_INIT:
                if (edges == D + 3) begin
                    if (legal(m_st)) begin
                        mst = M_RUN; m_s = m_st; m_v = 1;
                    end else begin
                        mst = M_SUS; m_v = 0; sus_bad = 0;
                    end
                end
            M_RUN:
                if (legal(m_st)) m_s = m_st;
                else begin
                    mst = M_SUS; sus_bad = 0;
                end
            M_SUS:
                if (legal(m_st)) begin
                    mst = M_RUN; m_s = m_st; m_v = 1;
                end else begin
                    sus_bad++;
                    if (sus_bad == F) begin
                        mst = M_FLT; m_f = 1; m_v = 0;
                    end
                end
            M_FLT:
                if (fault_clr && legal(m_st)) begin
                    mst = M_RUN; m_f = 0; m_s = m_st; m_v = 1;
                end
            default: ;
        endcase
`ifdef LSC_FAILSAFE_EN
        if (mst == M_FLT) m_s = 3'b000;
`endif
        m_st = nst;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        s_raw = 3'b000;
        fault_clr = 1'b0;
        model_reset();
        tick();
        tick();
        total++;
        if ({s, s_valid, fault} !== 5'b00000) begin
            bad++;
            $display("FAIL reset: got %b want 00000", {s, s_valid, fault});
        end
        reset = 1'b0;
    endtask

    task automatic test_startup();
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({s, s_valid, fault} !== {m_s, m_v, m_f}) begin
                bad++;
                $display("FAIL startup@%0d: got %b want %b", i,
                         {s, s_valid, fault}, {m_s, m_v, m_f});
            end
            total++;
            if (s_valid !== (i >= 7)) begin
                bad++;
                $display("FAIL startup_valid@%0d: got %b want %b", i,
                         s_valid, (i >= 7));
            end
        end
    endtask

    task automatic test_step();
        s_raw = 3'b001;
        repeat (12) tick();
        s_raw = 3'b011;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({s, s_valid, fault} !== {m_s, m_v, m_f}) begin
                bad++;
                $display("FAIL step@%0d: got %b want %b", i,
                         {s, s_valid, fault}, {m_s, m_v, m_f});
            end
            total++;
            if (s !== ((i < 7) ? 3'b001 : 3'b011)) begin
                bad++;
                $display("FAIL step_latency@%0d: got %b want %b", i, s,
                         (i < 7) ? 3'b001 : 3'b011);
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 15; i++) begin
            s_raw = (i < 3) ? 3'b111 : 3'b011;
            tick();
            total++;
            if ({s, s_valid, fault} !== 5'b01110) begin
                bad++;
                $display("FAIL glitch@%0d: got %b want 01110", i,
                         {s, s_valid, fault});
            end
        end
    endtask

    task automatic test_suspect();
        for (int i = 0; i < 20; i++) begin
            s_raw = (i < 5) ? 3'b101 : 3'b011;
            tick();
            total++;
            if ({s, s_valid, fault} !== {m_s, m_v, m_f}) begin
                bad++;
                $display("FAIL suspect@%0d: got %b want %b", i,
                         {s, s_valid, fault}, {m_s, m_v, m_f});
            end
            total++;
            if (s !== 3'b011 || fault !== 1'b0) begin
                bad++;
                $display("FAIL suspect_hold@%0d: got s=%b f=%b want s=011 f=0",
                         i, s, fault);
            end
        end
    endtask

    task automatic test_fault();
        logic [2:0] held;
`ifdef LSC_FAILSAFE_EN
        held = 3'b000;
`else
        held = 3'b011;
`endif
        s_raw = 3'b010;
        for (int i = 1; i <= 22; i++) begin
            fault_clr = (i == 21);
            tick();
            total++;
            if ({s, s_valid, fault} !== {m_s, m_v, m_f}) begin
                bad++;
                $display("FAIL fault_entry@%0d: got %b want %b", i,
                         {s, s_valid, fault}, {m_s, m_v, m_f});
            end
        end
        fault_clr = 1'b0;
        total++;
        if ({s, s_valid, fault} !== {held, 2'b01}) begin
            bad++;
            $display("FAIL fault_latched: got %b want %b",
                     {s, s_valid, fault}, {held, 2'b01});
        end
        s_raw = 3'b111;
        repeat (7) tick();
        total++;
        if (fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_wait: got %b want 1", fault);
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if ({s, s_valid, fault} !== 5'b11110) begin
            bad++;
            $display("FAIL fault_clear: got %b want 11110",
                     {s, s_valid, fault});
        end
    endtask

    task automatic test_async_reset();
        s_raw = 3'b010;
        repeat (25) tick();
        total++;
        if ({s_valid, fault} !== {m_v, m_f} || fault !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: got v=%b f=%b want v=0 f=1",
                     s_valid, fault);
        end
        @(posedge clk);
        model_step();
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++;
        if ({s, s_valid, fault} !== 5'b00000) begin
            bad++;
            $display("FAIL areset: got %b want 00000", {s, s_valid, fault});
        end
        @(negedge clk);
        s_raw = 3'b000;
        reset = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        logic [2:0] codes[4];
        codes[0] = 3'b000; codes[1] = 3'b001;
        codes[2] = 3'b011; codes[3] = 3'b111;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 7)
                    s_raw = codes[$urandom_range(0, 3)];
                else
                    s_raw = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 14);
            end
            hold--;
            fault_clr = ($urandom_range(0, 7) == 0);
            tick();
            total++;
            if ({s, s_valid, fault} !== {m_s, m_v, m_f}) begin
                bad++;
                $display("FAIL random@%0d: got %b want %b", i,
                         {s, s_valid, fault}, {m_s, m_v, m_f});
            end
            total++;
            if (!legal(s)) begin
                bad++;
                $display("FAIL random_legal@%0d: got %b want legal code", i, s);
            end
        end
        fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_step();
        test_glitch();
        test_suspect();
        test_fault();
        test_async_reset();
        test_startup();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/level_sensor_conditioner.md
Name: level_sensor_conditioner

Overview:
Upstream conditioning stage for the reservoir flow-rate controller. It synchronises and debounces the three raw float-sensor lines, checks that they form a legal thermometer code, and drives the clean s[2:0] bus the controller consumes. Persistent illegal codes raise a latched fault that is cleared by software.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive post-sync cycles a bit must differ from its stable value before the stable value updates (min 1).
FAULT_CYCLES, 8, consecutive cycles an illegal stable code is tolerated before FAULT (min 1).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
s_raw  in  3  raw sensor lines; bit0 is the lowest sensor; asynchronous to clk.
fault_clr  in  1  single-cycle pulse; requests exit from FAULT.
s  out  3  conditioned sensor code to the flow controller.
s_valid  out  1  s is trustworthy.
fault  out  1  latched sensor-inconsistency fault.

Behaviour:
- Reset, asynchronous and immediate: s=000, s_valid=0, fault=0; sync flops, stable bits and all counters go to 0; FSM enters INIT.
- Sync: s_raw passes through a 2-flop synchroniser per bit to give s_sync.
- Debounce, per bit:
  - If s_sync[i] != stable[i], cnt[i] increments.
  - When cnt[i]==DEBOUNCE_CYCLES-1 and the bit still differs, stable[i]<=s_sync[i] and cnt[i]<=0.
  - Any cycle with s_sync[i]==stable[i] clears cnt[i].
  - Any pulse shorter than DEBOUNCE_CYCLES post-sync cycles is rejected.
- Legal codes: 000, 001, 011, 111. All others are illegal.
- Output register: s<=stable only in RUN, and only when stable is legal.
- Latency: a clean step on s_raw appears on s after DEBOUNCE_CYCLES+3 rising edges (7 at default).
- FSM states and transitions:
  - INIT: a wait counter runs DEBOUNCE_CYCLES+3 cycles. At expiry, if stable is legal: go to RUN, load s, set s_valid=1. Otherwise go to SUSPECT with s_valid=0.
  - RUN: a legal stable value updates s. An illegal stable value moves to SUSPECT; s holds and s_valid stays as is.
  - SUSPECT: fcnt counts cycles with an illegal stable value.
    - Stable returns to legal: go to RUN, load s, set s_valid=1, clear fcnt.
    - fcnt reaches FAULT_CYCLES-1 while still illegal: go to FAULT. In that same edge fault=1 and s_valid=0.
  - FAULT: fault=1, s_valid=0, s holds its last legal value.
    - fault_clr with stable legal: go to RUN, fault=0, load s, set s_valid=1.
    - fault_clr with stable illegal: ignored.
- Simultaneous events: fault_clr outside FAULT is ignored. A stable update and the FSM transition in the same cycle use the new stable value on the following cycle.
- Reset mid-operation: applies the reset values immediately regardless of state; no clock is needed.

Optional Feature:
LSC_FAILSAFE_EN
- Defined: on entry to FAULT, and for as long as FAULT persists, s is forced to 000. The downstream controller then drives maximum supply flow.
- Undefined: s holds its last legal value in FAULT.
- All other behaviour is identical in both builds.

Decomposition:
- Package level_sensor_pkg:
  - FSM state enum: INIT, RUN, SUSPECT, FAULT.
  - Constants for the four legal codes.
  - Function is_legal_level(logic [2:0]).
- One sub-module, sensor_debounce: 1-bit synchroniser plus debounce counter, parameterised by DEBOUNCE_CYCLES, instantiated three times.
- The top level holds the legality check, FSM, fault counter and output register.

Test Plan:
1. Reset, then s_raw=000 held -> s=000 throughout; s_valid=1 after the 7th edge post-reset; fault=0.
2. In RUN, s_raw 001->011 step -> s=011 exactly 7 edges later; no intermediate value.
3. In RUN at 011, s_raw pulses to 111 for 3 cycles -> s stays 011; s_valid stays 1.
4. s_raw=101 held 5 cycles, then 011 -> SUSPECT then RUN; fault=0; s holds 011; no illegal value ever on s.
5. s_raw=010 held 20 cycles -> fault=1 and s_valid=0 after 8 SUSPECT cycles; fault_clr while 010 is ignored. Set s_raw=111 and wait 7 edges, then pulse fault_clr -> s=111, s_valid=1, fault=0. With LSC_FAILSAFE_EN, s=000 throughout FAULT.
6. Assert reset asynchronously while in FAULT -> s=000, s_valid=0, fault=0 before the next clk edge.
